// File: rtl/sparse_subtractor_serial_if.sv
// Handshake bundle for sparse_subtractor_serial.
// Operand side: in_valid/in_ready with a, b, bin.
// Result side: out_valid/out_ready with diff, bout and the optional flags.
// With SPARSE_SUB_FLAGS_EN defined, the bundle also carries zero and ovf.
interface sparse_subtractor_serial_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SPARSE_SUB_FLAGS_EN
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, zero, ovf
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, zero, ovf
   );
`else
   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout
   );
`endif
endinterface

// File: rtl/sparse_subtractor_serial.sv
// Multi-cycle wide subtractor: diff = a - b - bin, computed one 16-bit slice
// per clock through a sparse-tree adder with b inverted and carry-in = ~borrow.
// The borrow is registered between slices.
// Optional flags (zero, ovf) are built when SPARSE_SUB_FLAGS_EN is defined.
// WIDTH must be a multiple of 16 in the range 16..256.
//
// Handshake semantics (both sides):
//   - A transfer happens at a rising edge where valid and ready are both 1.
//   - in_ready is 1 only in IDLE, and is 0 while rst_n is held low.
//     An operation is accepted at the edge where in_valid && in_ready.
//   - out_valid is 1 only in DONE. diff, bout and the flags hold still until
//     the edge where out_ready is 1. The block then returns to IDLE, and
//     in_ready rises in the following cycle, so there is no same-cycle accept.
//   - in_valid while in_ready is 0 is ignored. There is no queuing.
module sparse_subtractor_serial #(
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   sparse_subtractor_serial_if.slave    bus,
   output logic [1:0]                   dbg_state
);

   localparam int NSLICE = WIDTH / 16;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, diff_q;
   logic [IDXW-1:0]  idx_q;
   logic             borrow_q, bout_q;
   logic             accept, step, last;
   logic [16:0]      slice_s;

   // 16-bit sparse-tree adder.
   // Group generate/propagate terms are formed every 4 bits, and a two-level
   // prefix over the groups produces the carries into bits 4, 8, 12 and 16.
   // Inside each group, both sums (carry-in 0 and carry-in 1) are precomputed
   // and the group carry selects between them.
   function automatic logic [16:0] sparse_add16(input logic [15:0] x,
                                                input logic [15:0] y,
                                                input logic        cin);
      logic [15:0] g, p, s;
      logic [3:0]  gg, gp, s0, s1;
      logic [4:0]  gc;
      logic        g10, p10, g32, p32, r0, r1;
      g = x & y;
      p = x ^ y;
      for (int k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) |
                 (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
                 (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
      end
      g10   = gg[1] | (gp[1] & gg[0]);
      p10   = gp[1] & gp[0];
      g32   = gg[3] | (gp[3] & gg[2]);
      p32   = gp[3] & gp[2];
      gc[0] = cin;
      gc[1] = gg[0] | (gp[0] & cin);
      gc[2] = g10 | (p10 & cin);
      gc[3] = gg[2] | (gp[2] & gc[2]);
      gc[4] = g32 | (p32 & gc[2]);
      s = '0;
      for (int k = 0; k < 4; k++) begin
         r0 = 1'b0;
         r1 = 1'b1;
         for (int i = 0; i < 4; i++) begin
            s0[i] = p[4*k+i] ^ r0;
            s1[i] = p[4*k+i] ^ r1;
            r0    = g[4*k+i] | (p[4*k+i] & r0);
            r1    = g[4*k+i] | (p[4*k+i] & r1);
         end
         s[4*k +: 4] = gc[k] ? s1 : s0;
      end
      return {gc[4], s};
   endfunction

   // Operands shift right as slices are consumed, so the live slice is
   // always in bits [15:0].
   always_comb begin
      slice_s = sparse_add16(a_q[15:0], ~b_q[15:0], ~borrow_q);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)     state_d = RUN;
         RUN:     if (idx_q == LAST_IDX) state_d = DONE;
         DONE:    if (bus.out_ready)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs and datapath strobes decoded from the state.
   // in_ready is masked by rst_n so that it stays low while reset is held.
   always_comb begin
      bus.in_ready  = (state_q == IDLE) && rst_n;
      bus.out_valid = (state_q == DONE);
      accept        = (state_q == IDLE) && bus.in_valid;
      step          = (state_q == RUN);
      last          = step && (idx_q == LAST_IDX);
      dbg_state     = state_q;
   end

   // Slice datapath: capture at accept, then one slice per RUN cycle.
   // Results hold through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
      end else if (accept) begin
         a_q      <= bus.a;
         b_q      <= bus.b;
         diff_q   <= '0;
         idx_q    <= '0;
         borrow_q <= bus.bin;
         bout_q   <= 1'b0;
      end else if (step) begin
         a_q      <= a_q >> 16;
         b_q      <= b_q >> 16;
         borrow_q <= ~slice_s[16];
         idx_q    <= last ? '0 : idx_q + IDXW'(1);
         for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IDXW'(k)) diff_q[16*k +: 16] <= slice_s[15:0];
         end
         if (last) bout_q <= ~slice_s[16];
      end
   end

   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

`ifdef SPARSE_SUB_FLAGS_EN
   logic sa_q, sb_q, zacc_q, zero_q, ovf_q;

   // Flags: zero is an AND of the per-slice zero tests accumulated across RUN.
   // ovf uses the operand sign bits captured at accept and the top slice's MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         zacc_q <= 1'b0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         sa_q   <= bus.a[WIDTH-1];
         sb_q   <= bus.b[WIDTH-1];
         zacc_q <= 1'b1;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (step) begin
         zacc_q <= zacc_q & (slice_s[15:0] == 16'h0);
         if (last) begin
            zero_q <= zacc_q & (slice_s[15:0] == 16'h0);
            ovf_q  <= (sa_q != sb_q) && (slice_s[15] != sa_q);
         end
      end
   end

   assign bus.zero = zero_q;
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sparse_subtractor_serial.sv
// Self-checking bench for sparse_subtractor_serial.
// It drives directed vectors with hand-computed results on a WIDTH=64 instance
// and a WIDTH=16 instance. Expected results go into queues, and monitors pop and
// compare them whenever the DUT completes an output handshake.
module tb_sparse_subtractor_serial;

   localparam int W = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] dbg64, dbg16;

   // Clock and reset
   always #5 clk = ~clk;

   sparse_subtractor_serial_if #(.WIDTH(W))  ifc ();
   sparse_subtractor_serial_if #(.WIDTH(16)) ifc16 ();

   sparse_subtractor_serial #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (ifc.slave),
      .dbg_state (dbg64)
   );

   sparse_subtractor_serial #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (ifc16.slave),
      .dbg_state (dbg16)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int acc16_cyc = 0;

   // Queue entries are {bout, zero, ovf, diff}.
   logic [W+2:0]  exp_q[$];
   logic [18:0]   exp16_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor for the 64-bit instance
   logic prev_ov = 1'b0;
   logic [W+2:0] e64;
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifc.out_valid && !prev_ov) chk("latency64", 64'(cyc - acc_cyc), 64'd4);
         if (ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out64: got diff %h with no expected entry", ifc.diff);
            end else begin
               e64 = exp_q.pop_front();
               chk("diff64", ifc.diff, e64[W-1:0]);
               chk("bout64", 64'(ifc.bout), 64'(e64[W+2]));
`ifdef SPARSE_SUB_FLAGS_EN
               chk("zero64", 64'(ifc.zero), 64'(e64[W+1]));
               chk("ovf64", 64'(ifc.ovf), 64'(e64[W]));
`endif
            end
         end
      end
      prev_ov <= ifc.out_valid;
   end

   // Scoreboard monitor for the 16-bit instance
   logic prev_ov16 = 1'b0;
   logic [18:0] e16;
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifc16.out_valid && !prev_ov16) chk("latency16", 64'(cyc - acc16_cyc), 64'd1);
         if (ifc16.out_valid && ifc16.out_ready) begin
            if (exp16_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out16: got diff %h with no expected entry", ifc16.diff);
            end else begin
               e16 = exp16_q.pop_front();
               chk("diff16", 64'(ifc16.diff), 64'(e16[15:0]));
               chk("bout16", 64'(ifc16.bout), 64'(e16[18]));
`ifdef SPARSE_SUB_FLAGS_EN
               chk("zero16", 64'(ifc16.zero), 64'(e16[17]));
               chk("ovf16", 64'(ifc16.ovf), 64'(e16[16]));
`endif
            end
         end
      end
      prev_ov16 <= ifc16.out_valid;
   end

   // Driver: present an operation and hold it until accepted
   task automatic accept_op(input logic [63:0] av, input logic [63:0] bv, input logic bi);
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.a        = av;
      ifc.b        = bv;
      ifc.bin      = bi;
      for (int i = 0; i < 50 && !ifc.in_ready; i++) @(negedge clk);
      if (!ifc.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout64: got in_ready=0 expected 1");
      end
      @(posedge clk);
      #1;
      acc_cyc      = cyc;
      ifc.in_valid = 1'b0;
   endtask

   task automatic drive_op(input logic [63:0] av, input logic [63:0] bv, input logic bi,
                           input logic [63:0] ed, input logic eb, input logic ez,
                           input logic eo);
      exp_q.push_back({eb, ez, eo, ed});
      accept_op(av, bv, bi);
   endtask

   task automatic drive16(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                          input logic [15:0] ed, input logic eb, input logic ez,
                          input logic eo);
      exp16_q.push_back({eb, ez, eo, ed});
      @(negedge clk);
      ifc16.in_valid = 1'b1;
      ifc16.a        = av;
      ifc16.b        = bv;
      ifc16.bin      = bi;
      for (int i = 0; i < 50 && !ifc16.in_ready; i++) @(negedge clk);
      if (!ifc16.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout16: got in_ready=0 expected 1");
      end
      @(posedge clk);
      #1;
      acc16_cyc      = cyc;
      ifc16.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && !(ifc.in_ready && exp_q.size() == 0); i++) @(negedge clk);
   endtask

   // Stimulus sequence
   initial begin
      ifc.in_valid    = 1'b0;
      ifc.a           = '0;
      ifc.b           = '0;
      ifc.bin         = 1'b0;
      ifc.out_ready   = 1'b1;
      ifc16.in_valid  = 1'b0;
      ifc16.a         = '0;
      ifc16.b         = '0;
      ifc16.bin       = 1'b0;
      ifc16.out_ready = 1'b1;

      // Power-on reset
      repeat (3) @(negedge clk);
      chk("rst_in_ready_held", 64'(ifc.in_ready), 64'd0);
      chk("rst_out_valid_held", 64'(ifc.out_valid), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready_rel", 64'(ifc.in_ready), 64'd1);
      chk("rst_out_valid_rel", 64'(ifc.out_valid), 64'd0);
      chk("rst_diff", ifc.diff, 64'd0);
      chk("rst_bout", 64'(ifc.bout), 64'd0);
`ifdef SPARSE_SUB_FLAGS_EN
      chk("rst_zero", 64'(ifc.zero), 64'd0);
      chk("rst_ovf", 64'(ifc.ovf), 64'd0);
`endif

      // Directed vectors: a, b, bin -> diff, bout, zero, ovf
      drive_op(64'h0000_0000_0001_0000, 64'h1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0);
      drive_op(64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
      drive_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
      drive_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
      drive_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
      drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0001_0001_0001_0001, 1'b1,
               64'hFFFE_FFFE_FFFE_FFFD, 1'b0, 1'b0, 1'b0);
      drive_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);

      // Backpressure in DONE, with an ignored in_valid pulse
      wait_idle();
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b0;
      drive_op(64'h10, 64'h5, 1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 30 && !ifc.out_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("hold_out_valid", 64'(ifc.out_valid), 64'd1);
         chk("hold_in_ready", 64'(ifc.in_ready), 64'd0);
         chk("hold_diff", ifc.diff, 64'hA);
         chk("hold_bout", 64'(ifc.bout), 64'd0);
         if (i == 1) begin
            ifc.in_valid = 1'b1;
            ifc.a        = 64'hFFFF_FFFF_FFFF_FFFF;
            ifc.b        = 64'h0;
         end else begin
            ifc.in_valid = 1'b0;
         end
         @(negedge clk);
      end
      ifc.in_valid = 1'b0;
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_out_valid", 64'(ifc.out_valid), 64'd0);
      chk("release_in_ready", 64'(ifc.in_ready), 64'd1);
      repeat (6) @(negedge clk);
      chk("no_phantom_op", 64'(ifc.out_valid), 64'd0);

      // Reset in the middle of a run aborts it
      accept_op(64'hDEAD_BEEF_0000_1111, 64'h1111_2222_3333_4444, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 64'(ifc.in_ready), 64'd0);
      chk("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
      chk("midrst_diff", ifc.diff, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrel_in_ready", 64'(ifc.in_ready), 64'd1);
      chk("midrel_out_valid", 64'(ifc.out_valid), 64'd0);
      chk("midrel_diff", ifc.diff, 64'd0);
      chk("midrel_bout", 64'(ifc.bout), 64'd0);
      drive_op(64'h0000_0001_0000_0000, 64'h1, 1'b1, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

      // WIDTH=16 instance: single-slice operation
      drive16(16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      drive16(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      drive16(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Drain and report
      for (int i = 0; i < 100 && (exp_q.size() != 0 || exp16_q.size() != 0); i++) @(negedge clk);
      chk("drain64", 64'(exp_q.size()), 64'd0);
      chk("drain16", 64'(exp16_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sparse_subtractor_serial.md
Name: sparse_subtractor_serial

Overview:
- Multi-cycle wide subtractor: computes diff = a - b - bin for WIDTH-bit operands, one 16-bit slice per clock.
- Each slice uses a sparse-tree carry network with b inverted and carry-in = ~borrow; the borrow is registered between slices.
- Counterpart (subtract direction) of the team's 16-bit sparse adder. Used where wide subtraction is needed without a full-width combinational carry tree.
- valid/ready handshake on both input and output.

Parameters:
- WIDTH, 64, operand width in bits; must be a multiple of 16, range 16..256. Internal NSLICE = WIDTH/16.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and bin valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  final borrow out (1 = unsigned underflow)
- zero  output  1  diff == 0 (SPARSE_SUB_FLAGS_EN only)
- ovf  output  1  signed overflow (SPARSE_SUB_FLAGS_EN only)

Behaviour:
- Reset: async, active-low, one clock domain. Asserting rst_n low forces:
  - state IDLE;
  - in_ready=0 while reset is held, in_ready=1 on the first cycle after release;
  - out_valid=0, diff=0, bout=0, zero=0, ovf=0;
  - slice index and borrow register cleared.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- State IDLE: in_ready=1, out_valid=0.
  - On in_valid && in_ready at a clock edge (edge E0): capture a, b; set borrow=bin, idx=0; go to RUN.
- State RUN: in_ready=0. At each edge, slice idx is computed as:
  - s = a[16idx+:16] + ~b[16idx+:16] + ~borrow (17-bit result);
  - diff[16idx+:16] <= s[15:0];
  - borrow <= ~s[16];
  - idx increments.
  - At the edge where idx==NSLICE-1: go to DONE and set out_valid=1, bout = final borrow.
  - Latency: out_valid is visible NSLICE cycles after E0 (4 cycles at WIDTH=64).
- Slice arithmetic:
  - 16-bit sparse-tree prefix network: generate/propagate pairs, group carries every 4 bits, carry-select sum muxes within each 4-bit group.
  - Must be single-cycle combinational and bit-exact to the expression above.
- State DONE: out_valid=1. diff, bout and flags are held stable while out_ready=0. in_ready=0, and in_valid is ignored.
  - On out_ready at an edge: out_valid <= 0, go to IDLE.
  - in_ready returns to 1 in the following cycle; no same-cycle accept.
  - Minimum initiation interval is NSLICE+2 cycles.
- diff bits of not-yet-computed slices are don't-care while out_valid=0, but are cleared at accept.
- in_valid while in_ready=0 has no effect; there is no queuing.
- X on a, b or bin is permitted when not being accepted.

Optional Feature:
- Macro: SPARSE_SUB_FLAGS_EN.
- Defined: ports zero and ovf exist and are registered, valid with out_valid.
  - zero = (diff == 0). Accumulate a per-slice zero AND across RUN.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]).
  - Both are held in DONE and reset to 0.
- Undefined: zero and ovf ports and their logic are absent. All other behaviour is identical.

Test Plan:
All scenarios use WIDTH=64 unless noted.
- Reset: rst_n=0 mid-run, then release -> in_ready=1, out_valid=0, diff=0, bout=0 on the first cycle after release; a new op is then accepted normally.
- Cross-slice borrow: a=0x0000_0000_0001_0000, b=0x1, bin=0 -> diff=0x0000_0000_0000_FFFF, bout=0. out_valid rises exactly 4 cycles after the accept edge.
- Underflow: a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, zero=0, ovf=0.
- Signed overflow: a=0x8000_0000_0000_0000, b=1, bin=0 -> diff=0x7FFF_FFFF_FFFF_FFFF, bout=0, ovf=1.
- Equal operands: a=b=0x1234_5678_9ABC_DEF0, bin=0 -> diff=0, zero=1, bout=0. Repeat with bin=1 -> diff=all F, bout=1, zero=0.
- Backpressure and ignore:
  - Hold out_ready=0 for 5 cycles in DONE -> diff, bout and out_valid stay stable; in_ready=0; an in_valid pulse is not accepted.
  - Raise out_ready -> out_valid falls at the next edge, and in_ready=1 the cycle after.
  - Also run WIDTH=16 -> latency 1 cycle.
